// File: rtl/i2c_eeprom_ptr_ctrl.sv
// Byte-level EEPROM engine: big-endian pointer load, read prefetch with auto-increment.
// Define I2C_EEPROM_WR_EN to enable array writes; otherwise data bytes are NACKed.
module i2c_eeprom_ptr_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              in_ext_osc,
  input  logic              in_reset_n,
  input  logic              in_start,
  input  logic              in_stop,
  input  logic              in_addr_hit,
  input  logic              in_rw,
  input  logic              in_rx_valid,
  input  logic [7:0]        in_rx_data,
  output logic              out_rx_ack,
  input  logic              in_tx_load,
  input  logic              in_mst_nack,
  output logic [7:0]        out_tx_data,
  output logic              out_tx_valid,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_rd,
  input  logic [7:0]        in_mem_rdata,
  output logic              out_mem_we,
  output logic [7:0]        out_mem_wdata,
  output logic [ADDR_W-1:0] out_ptr
);

  // Pointer bytes are assembled in a vector of at least 16 bits; excess MSBs drop on load.
  localparam int unsigned PW = (ADDR_W > 16) ? ADDR_W : 16;

  typedef enum logic [2:0] {
    StIdle,
    StPtrHi,
    StPtrLo,
    StWdata,
    StRdFetch,
    StRdReady,
    StRdDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              mem_rd_q;
  logic              rx_ack_q;
  logic [1:0]        lat_cnt_q;

  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] ptr_cur;
  logic [PW-1:0]     ptr_wide;
  logic [PW-1:0]     ptr_hi_ld;
  logic [PW-1:0]     ptr_lo_ld;

`ifdef I2C_EEPROM_WR_EN
  logic              mem_we_q;
  logic [7:0]        wdata_q;
  logic              wr_inc_q;

  // A write's increment lands one clock later; ptr_cur folds in that pending step.
  assign ptr_cur = wr_inc_q ? ptr_inc : ptr_q;
`else
  assign ptr_cur = ptr_q;
`endif

  always_comb begin
    ptr_inc          = ptr_q + ADDR_W'(1);
    ptr_wide         = PW'(ptr_cur);
    ptr_hi_ld        = ptr_wide;
    ptr_hi_ld[15:8]  = in_rx_data;
    ptr_lo_ld        = ptr_wide;
    ptr_lo_ld[7:0]   = in_rx_data;
  end

  always_ff @(posedge in_ext_osc or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      mem_addr_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      rx_ack_q   <= 1'b1;
      lat_cnt_q  <= 2'd0;
`ifdef I2C_EEPROM_WR_EN
      mem_we_q   <= 1'b0;
      wdata_q    <= 8'h00;
      wr_inc_q   <= 1'b0;
`endif
    end else begin
      mem_rd_q <= 1'b0;
`ifdef I2C_EEPROM_WR_EN
      mem_we_q <= 1'b0;
      if (wr_inc_q) begin
        ptr_q    <= ptr_inc;
        wr_inc_q <= 1'b0;
      end
`endif
      if (in_start || in_stop) begin
        // Bus framing aborts any phase; the pointer survives for current-address reads.
        state_q    <= StIdle;
        tx_valid_q <= 1'b0;
        rx_ack_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (in_addr_hit) begin
              if (in_rw) begin
                state_q    <= StRdFetch;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= ptr_cur;
                lat_cnt_q  <= 2'd0;
              end else begin
                state_q <= StPtrHi;
              end
            end
          end
          StPtrHi: begin
            if (in_rx_valid) begin
              ptr_q   <= ptr_hi_ld[ADDR_W-1:0];
              state_q <= StPtrLo;
            end
          end
          StPtrLo: begin
            if (in_rx_valid) begin
              ptr_q   <= ptr_lo_ld[ADDR_W-1:0];
              state_q <= StWdata;
`ifndef I2C_EEPROM_WR_EN
              rx_ack_q <= 1'b0;
`endif
            end
          end
          StWdata: begin
`ifdef I2C_EEPROM_WR_EN
            if (in_rx_valid) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= ptr_cur;
              wdata_q    <= in_rx_data;
              wr_inc_q   <= 1'b1;
            end
`endif
          end
          StRdFetch: begin
            if (in_mst_nack) begin
              state_q <= StRdDone;
            end else if (lat_cnt_q == 2'(RD_LAT)) begin
              tx_data_q  <= in_mem_rdata;
              tx_valid_q <= 1'b1;
              state_q    <= StRdReady;
            end else begin
              lat_cnt_q <= lat_cnt_q + 2'd1;
            end
          end
          StRdReady: begin
            if (in_tx_load) begin
              ptr_q      <= ptr_inc;
              tx_valid_q <= 1'b0;
              state_q    <= StRdFetch;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= ptr_inc;
              lat_cnt_q  <= 2'd0;
            end else if (in_mst_nack) begin
              tx_valid_q <= 1'b0;
              state_q    <= StRdDone;
            end
          end
          StRdDone: begin
            tx_valid_q <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign out_rx_ack   = rx_ack_q;
  assign out_tx_data  = tx_data_q;
  assign out_tx_valid = tx_valid_q;
  assign out_mem_addr = mem_addr_q;
  assign out_mem_rd   = mem_rd_q;
  assign out_ptr      = ptr_q;
`ifdef I2C_EEPROM_WR_EN
  assign out_mem_we    = mem_we_q;
  assign out_mem_wdata = wdata_q;
`else
  assign out_mem_we    = 1'b0;
  assign out_mem_wdata = 8'h00;
`endif

endmodule

// File: tb/tb_i2c_eeprom_ptr_ctrl.sv
// Bench for i2c_eeprom_ptr_ctrl: vector table, hand-written corner sequences and random
// transactions checked against a byte-array memory and an integer pointer model.
module tb_i2c_eeprom_ptr_ctrl;

  localparam int unsigned RD_LAT = 1;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        stop     = 1'b0;
  logic        addr_hit = 1'b0;
  logic        rw       = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        tx_load  = 1'b0;
  logic        mst_nack = 1'b0;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [15:0] ptr;

  i2c_eeprom_ptr_ctrl #(
    .ADDR_W (16),
    .RD_LAT (RD_LAT)
  ) dut (
    .in_ext_osc    (clk),
    .in_reset_n    (rst_n),
    .in_start      (start),
    .in_stop       (stop),
    .in_addr_hit   (addr_hit),
    .in_rw         (rw),
    .in_rx_valid   (rx_valid),
    .in_rx_data    (rx_data),
    .out_rx_ack    (rx_ack),
    .in_tx_load    (tx_load),
    .in_mst_nack   (mst_nack),
    .out_tx_data   (tx_data),
    .out_tx_valid  (tx_valid),
    .out_mem_addr  (mem_addr),
    .out_mem_rd    (mem_rd),
    .in_mem_rdata  (mem_rdata),
    .out_mem_we    (mem_we),
    .out_mem_wdata (mem_wdata),
    .out_ptr       (ptr)
  );

  always #5 clk = ~clk;

  // Memory: data valid only in the cycle after the read strobe, junk otherwise.
  logic [7:0]  mem [0:65535];
  logic        rd_d    = 1'b0;
  logic [7:0]  rdata_r = 8'h00;
  logic [7:0]  junk    = 8'h00;
  int          we_count = 0;
  logic [23:0] wr_log [$];

  always @(posedge clk) begin
    rd_d <= mem_rd;
    junk <= 8'($urandom);
    if (mem_rd) rdata_r <= mem[mem_addr];
    if (mem_we) begin
      we_count <= we_count + 1;
      wr_log.push_back({mem_addr, mem_wdata});
    end
  end
  assign mem_rdata = rd_d ? rdata_r : junk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_ptr = 16'h0000;

  typedef struct {
    logic        wr_ptr;
    logic [15:0] ptr;
    logic        rstart;
    int          nbytes;
    logic [15:0] exp_end;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic p, input logic h, input logic r,
                       input logic rx, input logic [7:0] d, input logic ld, input logic nk);
    @(negedge clk);
    start = s; stop = p; addr_hit = h; rw = r; rx_valid = rx; rx_data = d;
    tx_load = ld; mst_nack = nk;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; addr_hit = 1'b0; rw = 1'b0; rx_valid = 1'b0;
    tx_load = 1'b0; mst_nack = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!tx_valid && k < int'(RD_LAT) + 2) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(tx_valid), 32'd1);
  endtask

  task automatic write_ptr(input logic [15:0] p, input logic rstart);
    pulse(1, 0, 0, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 1, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 0, 0, 1, p[15:8], 0, 0);
    check("ptr_hi_ack", 32'(rx_ack), 32'd1);
    pulse(0, 0, 0, 0, 1, p[7:0], 0, 0);
    model_ptr = p;
    check("ptr_loaded", 32'(ptr), 32'(model_ptr));
    if (!rstart) pulse(0, 1, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic read_txn(input int n);
    pulse(1, 0, 0, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 1, 1, 0, 8'h00, 0, 0);
    check("rd_strobe", 32'(mem_rd), 32'd1);
    check("rd_addr", 32'(mem_addr), 32'(model_ptr));
    for (int i = 0; i < n; i++) begin
      wait_valid("rd_latency");
      check("rd_data", 32'(tx_data), 32'(mem[model_ptr]));
      idle(int'($urandom_range(0, 3)));
      pulse(0, 0, 0, 0, 0, 8'h00, 1, 0);
      model_ptr = model_ptr + 16'd1;
      check("ptr_inc", 32'(ptr), 32'(model_ptr));
      check("valid_drop", 32'(tx_valid), 32'd0);
      check("prefetch_addr", 32'(mem_addr), 32'(model_ptr));
    end
    idle(3);
    pulse(0, 0, 0, 0, 0, 8'h00, 0, 1);
    check("nack_valid", 32'(tx_valid), 32'd0);
    check("nack_ptr", 32'(ptr), 32'(model_ptr));
    pulse(0, 1, 0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    logic [15:0] exp_end;
    logic        rs;
    int          n;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    vecs[0] = '{wr_ptr: 1'b1, ptr: 16'h0001, rstart: 1'b0, nbytes: 4, exp_end: 16'h0005};
    vecs[1] = '{wr_ptr: 1'b1, ptr: 16'hAACC, rstart: 1'b1, nbytes: 8, exp_end: 16'hAAD4};
    vecs[2] = '{wr_ptr: 1'b0, ptr: 16'h0000, rstart: 1'b0, nbytes: 3, exp_end: 16'hAAD7};
    vecs[3] = '{wr_ptr: 1'b1, ptr: 16'hFFFC, rstart: 1'b0, nbytes: 8, exp_end: 16'h0004};
    vecs[4] = '{wr_ptr: 1'b1, ptr: 16'hFFFE, rstart: 1'b1, nbytes: 2, exp_end: 16'h0000};
    vecs[5] = '{wr_ptr: 1'b0, ptr: 16'h0000, rstart: 1'b0, nbytes: 1, exp_end: 16'h0001};

    idle(3);
    check("rst_rx_ack", 32'(rx_ack), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].wr_ptr) write_ptr(vecs[v].ptr, vecs[v].rstart);
      read_txn(vecs[v].nbytes);
      check($sformatf("vec%0d_end_ptr", v), 32'(ptr), 32'(vecs[v].exp_end));
    end

    // START coinciding with a byte drops the byte; the high byte stays loaded.
    write_ptr(16'h3C77, 1'b0);
    pulse(1, 0, 0, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 1, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 0, 0, 1, 8'h12, 0, 0);
    pulse(1, 0, 0, 0, 1, 8'h34, 0, 0);
    model_ptr = (16'h0012 << 8) | (model_ptr & 16'h00FF);
    check("start_drops_byte", 32'(ptr), 32'(model_ptr));
    // STOP after only the high byte keeps the old low byte.
    pulse(0, 0, 1, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 0, 0, 1, 8'h5B, 0, 0);
    pulse(0, 1, 0, 0, 0, 8'h00, 0, 0);
    model_ptr = (16'h005B << 8) | (model_ptr & 16'h00FF);
    check("stop_after_hi", 32'(ptr), 32'(model_ptr));
    read_txn(2);

    // Load held two clocks: the second arrives with no valid byte and must not advance.
    write_ptr(16'h0100, 1'b0);
    pulse(1, 0, 0, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 1, 1, 0, 8'h00, 0, 0);
    wait_valid("dbl_latency");
    check("dbl_data0", 32'(tx_data), 32'(mem[model_ptr]));
    @(negedge clk); tx_load = 1'b1;
    @(negedge clk);
    @(negedge clk); tx_load = 1'b0;
    model_ptr = model_ptr + 16'd1;
    check("stale_load_ptr", 32'(ptr), 32'(model_ptr));
    wait_valid("dbl_latency1");
    check("dbl_data1", 32'(tx_data), 32'(mem[model_ptr]));
    pulse(0, 0, 0, 0, 0, 8'h00, 0, 1);
    pulse(0, 0, 0, 0, 0, 8'h00, 1, 0);
    check("done_load_ptr", 32'(ptr), 32'(model_ptr));
    check("done_load_valid", 32'(tx_valid), 32'd0);
    pulse(0, 1, 0, 0, 0, 8'h00, 0, 0);

    // Data bytes after the pointer.
    write_ptr(16'h0010, 1'b1);
`ifdef I2C_EEPROM_WR_EN
    check("wdata_ack", 32'(rx_ack), 32'd1);
    pulse(0, 0, 0, 0, 1, 8'h5A, 0, 0);
    idle(1);
    pulse(0, 0, 0, 0, 1, 8'hA5, 0, 0);
    idle(2);
    check("wdata_ack2", 32'(rx_ack), 32'd1);
    check("wr_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      check("wr0", 32'(wr_log[0]), 32'h00105A);
      check("wr1", 32'(wr_log[1]), 32'h0011A5);
    end
    check("wr_ptr_end", 32'(ptr), 32'h0012);
    pulse(0, 1, 0, 0, 0, 8'h00, 0, 0);
    mem[16'h0010] = 8'h5A;
    mem[16'h0011] = 8'hA5;
    write_ptr(16'h0010, 1'b0);
    read_txn(2);
`else
    check("wdata_nack", 32'(rx_ack), 32'd0);
    pulse(0, 0, 0, 0, 1, 8'h5A, 0, 0);
    check("wdata_nack2", 32'(rx_ack), 32'd0);
    pulse(0, 0, 0, 0, 1, 8'hA5, 0, 0);
    idle(2);
    check("ro_no_we", 32'(we_count), 32'd0);
    check("ro_ptr_kept", 32'(ptr), 32'h0010);
    pulse(0, 1, 0, 0, 0, 8'h00, 0, 0);
    check("ack_after_stop", 32'(rx_ack), 32'd1);
`endif

    // Reset in the middle of a read.
    write_ptr(16'h1234, 1'b0);
    pulse(1, 0, 0, 0, 0, 8'h00, 0, 0);
    pulse(0, 0, 1, 1, 0, 8'h00, 0, 0);
    wait_valid("pre_reset_valid");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_ptr", 32'(ptr), 32'd0);
    check("midrst_rx_ack", 32'(rx_ack), 32'd1);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    model_ptr = 16'h0000;
    idle(2);
    write_ptr(16'h0777, 1'b0);
    read_txn(3);

    // Random transactions.
    for (int it = 0; it < 24; it++) begin
      n  = int'($urandom_range(1, 6));
      rs = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        p = ($urandom_range(0, 2) == 0) ? 16'hFFFF - 16'($urandom_range(0, 4)) : 16'($urandom);
        write_ptr(p, rs);
      end
      exp_end = model_ptr + 16'(n);
      read_txn(n);
      check("rand_end_ptr", 32'(ptr), 32'(exp_end));
    end

`ifndef I2C_EEPROM_WR_EN
    check("ro_never_we", 32'(we_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
